// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing and test-pattern generator.
// A pixel-enable divider feeds the horizontal and vertical counters. Every
// output is a registered decode of the counter state, so the outputs trail
// the counters by one system clock. The pattern select is sampled only at
// the end of a frame.
module vga_pattern_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 2,
   parameter int SYNC_POL = 0,
   parameter int COLOR_W  = 4,
   parameter int CHK_LOG2 = 4,
   parameter int X_W      = 10,
   parameter int Y_W      = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         mode,
   output logic               h_sync,
   output logic               v_sync,
   output logic [COLOR_W-1:0] r_out,
   output logic [COLOR_W-1:0] g_out,
   output logic [COLOR_W-1:0] b_out,
   output logic               video_on,
   output logic               frame_start,
   output logic [X_W-1:0]     x,
   output logic [Y_W-1:0]     y
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [X_W-1:0]   H_LAST     = X_W'(H_TOTAL - 1);
   localparam logic [X_W-1:0]   H_VIS      = X_W'(H_ACTIVE);
   localparam logic [X_W-1:0]   H_SS       = X_W'(H_ACTIVE + H_FP);
   localparam logic [X_W-1:0]   H_SE       = X_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [Y_W-1:0]   V_LAST     = Y_W'(V_TOTAL - 1);
   localparam logic [Y_W-1:0]   V_VIS      = Y_W'(V_ACTIVE);
   localparam logic [Y_W-1:0]   V_SS       = Y_W'(V_ACTIVE + V_FP);
   localparam logic [Y_W-1:0]   V_SE       = Y_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [X_W-1:0]   BAR_LAST   = X_W'(BAR_W - 1);
   localparam logic             SYNC_ACT   = (SYNC_POL != 0);

   logic [DIV_W-1:0]   div_cnt;
   logic [X_W-1:0]     h_cnt;
   logic [Y_W-1:0]     v_cnt;
   logic [1:0]         mode_q;
   logic [2:0]         bar_idx;
   logic [X_W-1:0]     bar_sub;
   logic               tick;

   logic               vis_d;
   logic               hs_d;
   logic               vs_d;
   logic               fs_d;
   logic [COLOR_W-1:0] red_d;
   logic [COLOR_W-1:0] green_d;
   logic [COLOR_W-1:0] blue_d;

   assign tick = (div_cnt == DIV_LAST);

   // Divider, raster counters, the colour-bar tracker and frame-aligned mode latch.
   // The bar tracker follows h_cnt pixel by pixel so no divide is needed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
         h_cnt   <= '0;
         v_cnt   <= '0;
         mode_q  <= '0;
         bar_idx <= '0;
         bar_sub <= '0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick) begin
            if (h_cnt == H_LAST) begin
               h_cnt   <= '0;
               bar_idx <= '0;
               bar_sub <= '0;
               if (v_cnt == V_LAST) begin
                  v_cnt  <= '0;
                  mode_q <= mode;
               end else begin
                  v_cnt <= v_cnt + 1'b1;
               end
            end else begin
               h_cnt <= h_cnt + 1'b1;
               if (bar_sub == BAR_LAST) begin
                  bar_sub <= '0;
                  if (bar_idx != 3'd7)
                     bar_idx <= bar_idx + 1'b1;
               end else begin
                  bar_sub <= bar_sub + 1'b1;
               end
            end
         end
      end
   end

   // Decode sync windows, visibility, frame start and pixel colour from the current counters.
   always_comb begin
      vis_d   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      hs_d    = ((h_cnt >= H_SS) && (h_cnt < H_SE)) ? SYNC_ACT : ~SYNC_ACT;
      vs_d    = ((v_cnt >= V_SS) && (v_cnt < V_SE)) ? SYNC_ACT : ~SYNC_ACT;
      fs_d    = (h_cnt == '0) && (v_cnt == '0) && (div_cnt == '0);
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
      if (vis_d) begin
         case (mode_q)
            2'd0: begin
               red_d   = '1;
               green_d = '1;
               blue_d  = '1;
            end
            2'd1: begin
               red_d   = {COLOR_W{bar_idx[2]}};
               green_d = {COLOR_W{bar_idx[1]}};
               blue_d  = {COLOR_W{bar_idx[0]}};
            end
            2'd2: begin
               if (h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]) begin
                  red_d   = '1;
                  green_d = '1;
                  blue_d  = '1;
               end
            end
            default: begin
               red_d   = h_cnt[COLOR_W-1:0];
               green_d = v_cnt[COLOR_W-1:0];
               blue_d  = ~h_cnt[COLOR_W-1:0];
            end
         endcase
      end
   end

   // Register every output so the DAC sees glitch-free levels.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_sync      <= ~SYNC_ACT;
         v_sync      <= ~SYNC_ACT;
         r_out       <= '0;
         g_out       <= '0;
         b_out       <= '0;
         video_on    <= 1'b0;
         frame_start <= 1'b0;
         x           <= '0;
         y           <= '0;
      end else begin
         h_sync      <= hs_d;
         v_sync      <= vs_d;
         r_out       <= red_d;
         g_out       <= green_d;
         b_out       <= blue_d;
         video_on    <= vis_d;
         frame_start <= fs_d;
         x           <= vis_d ? h_cnt : '0;
         y           <= vis_d ? v_cnt : '0;
      end
   end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen on a tiny 24x12 raster.
// dut runs with CLK_DIV=2 and active-low syncs; dut2 runs with CLK_DIV=1 and
// active-high syncs. n_cur is the raster clock index the outputs currently show.
module tb_vga_pattern_gen;

   logic       clk;
   logic       rst;
   logic [1:0] mode;

   logic       h_sync, v_sync, video_on, frame_start;
   logic [3:0] r_out, g_out, b_out;
   logic [9:0] x, y;

   logic       h_sync2, v_sync2, video_on2, frame_start2;
   logic [3:0] r_out2, g_out2, b_out2;
   logic [9:0] x2, y2;

   int vectors     = 0;
   int miscompares = 0;
   int n_cur       = -1;
   bit meas        = 0;

   int fs_pos [16];
   int fs_n       = 0;
   int fs2_pos [16];
   int fs2_n      = 0;
   int vid_cnt    = 0;
   int vid_blank  = 0;
   int hs_cnt     = 0;
   int hs_first   = -1;
   int hs_line0   = 0;
   int vs_cnt     = 0;
   int vs_first   = -1;
   int hs2_cnt    = 0;
   int hs2_line0  = 0;

   vga_pattern_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
      .CLK_DIV(2), .SYNC_POL(0), .COLOR_W(4), .CHK_LOG2(1),
      .X_W(10), .Y_W(10)
   ) dut (
      .clk(clk), .rst(rst), .mode(mode),
      .h_sync(h_sync), .v_sync(v_sync),
      .r_out(r_out), .g_out(g_out), .b_out(b_out),
      .video_on(video_on), .frame_start(frame_start),
      .x(x), .y(y)
   );

   vga_pattern_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
      .CLK_DIV(1), .SYNC_POL(1), .COLOR_W(4), .CHK_LOG2(1),
      .X_W(10), .Y_W(10)
   ) dut2 (
      .clk(clk), .rst(rst), .mode(mode),
      .h_sync(h_sync2), .v_sync(v_sync2),
      .r_out(r_out2), .g_out(g_out2), .b_out(b_out2),
      .video_on(video_on2), .frame_start(frame_start2),
      .x(x2), .y(y2)
   );

   // Free-running system clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; outputs are sampled on the falling edge and folded into the statistics.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      n_cur++;
      if (meas) begin
         if (frame_start) begin
            if (fs_n < 16) fs_pos[fs_n] = n_cur;
            fs_n++;
         end
         if (frame_start2) begin
            if (fs2_n < 16) fs2_pos[fs2_n] = n_cur;
            fs2_n++;
         end
         if (n_cur < 576) begin
            if (video_on) vid_cnt++;
            if (video_on && n_cur >= 384) vid_blank++;
            if (!h_sync) begin
               hs_cnt++;
               if (hs_first < 0) hs_first = n_cur;
               if (n_cur < 48) hs_line0++;
            end
            if (!v_sync) begin
               vs_cnt++;
               if (vs_first < 0) vs_first = n_cur;
            end
         end
         if (n_cur < 288 && h_sync2) begin
            hs2_cnt++;
            if (n_cur < 24) hs2_line0++;
         end
      end
   endtask

   function automatic int pix(input int f, input int h, input int v);
      return f * 576 + (v * 24 + h) * 2;
   endfunction

   task automatic wait_idx(input int target);
      int guard;
      guard = 0;
      while (n_cur < target && guard < 4000) begin
         step();
         guard++;
      end
      check_output("reach", n_cur, target);
   endtask

   task automatic check_pix(input string tag, input int f, input int h, input int v,
                            input logic [11:0] rgb, input logic vis);
      wait_idx(pix(f, h, v));
      check_output({tag, "_rgb"}, {r_out, g_out, b_out}, rgb);
      check_output({tag, "_vis"}, video_on, vis);
      check_output({tag, "_x"}, x, vis ? h : 0);
      check_output({tag, "_y"}, y, vis ? v : 0);
   endtask

   // Linear directed sequence.
   initial begin
      rst  = 1'b1;
      mode = 2'd0;
      #3 rst = 1'b0;
      #1;
      check_output("rst_hs", h_sync, 1'b1);
      check_output("rst_vs", v_sync, 1'b1);
      check_output("rst_rgb", {r_out, g_out, b_out}, 12'h000);
      check_output("rst_vis", video_on, 1'b0);
      check_output("rst_fs", frame_start, 1'b0);
      check_output("rst_xy", {x, y}, 20'h0);
      check_output("rst_hs2", h_sync2, 1'b0);
      check_output("rst_vs2", v_sync2, 1'b0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst   = 1'b1;
      n_cur = -1;
      meas  = 1;

      step();
      check_output("fs_first", frame_start, 1'b1);
      check_output("px00_rgb", {r_out, g_out, b_out}, 12'hFFF);
      step();
      check_output("fs_second_clk", frame_start, 1'b0);

      // Frame 0 stays white although mode is switched part way through.
      check_pix("f0_3_2", 0, 3, 2, 12'hFFF, 1'b1);
      mode = 2'd1;
      check_pix("f0_20_2", 0, 20, 2, 12'h000, 1'b0);
      check_pix("f0_12_5", 0, 12, 5, 12'hFFF, 1'b1);

      // Frame 1: colour bars, two pixels per bar.
      check_pix("bar_0", 1, 0, 0, 12'h000, 1'b1);
      check_output("fs_f1", frame_start, 1'b1);
      check_pix("bar_2", 1, 2, 0, 12'h00F, 1'b1);
      check_pix("bar_6", 1, 6, 0, 12'h0FF, 1'b1);
      check_pix("bar_8", 1, 8, 0, 12'hF00, 1'b1);
      mode = 2'd2;
      check_pix("bar_14", 1, 14, 0, 12'hFFF, 1'b1);
      check_pix("bar_18", 1, 18, 0, 12'h000, 1'b0);
      check_pix("bar_3_5", 1, 3, 5, 12'h00F, 1'b1);

      // Frame 0 statistics are complete by now.
      check_output("vid_total", vid_cnt, 256);
      check_output("vid_blank_lines", vid_blank, 0);
      check_output("hs_total", hs_cnt, 72);
      check_output("hs_line0", hs_line0, 6);
      check_output("hs_first", hs_first, 36);
      check_output("vs_total", vs_cnt, 96);
      check_output("vs_first", vs_first, 432);
      check_output("hs2_total", hs2_cnt, 36);
      check_output("hs2_line0", hs2_line0, 3);

      // Frame 2: checkerboard with 2-pixel squares.
      check_pix("chk_0_0", 2, 0, 0, 12'h000, 1'b1);
      check_pix("chk_2_0", 2, 2, 0, 12'hFFF, 1'b1);
      check_pix("chk_0_2", 2, 0, 2, 12'hFFF, 1'b1);
      check_pix("chk_2_2", 2, 2, 2, 12'h000, 1'b1);
      mode = 2'd3;

      // Frame 3: gradient.
      check_pix("grad_5_3", 3, 5, 3, 12'h53A, 1'b1);
      check_pix("grad_15_7", 3, 15, 7, 12'hF70, 1'b1);
      check_pix("grad_10_4", 4, 10, 4, 12'hA45, 1'b1);

      check_output("fs_count", fs_n, 5);
      check_output("fs_pos1", fs_pos[1], 576);
      check_output("fs_pos2", fs_pos[2], 1152);
      check_output("fs_pos4", fs_pos[4], 2304);
      check_output("fs2_count", fs2_n, 9);
      check_output("fs2_pos1", fs2_pos[1], 288);
      check_output("fs2_pos8", fs2_pos[8], 2304);

      // Mid-frame reset: outputs clear immediately and timing restarts at (0,0) in mode 0.
      meas = 0;
      rst  = 1'b0;
      #1;
      check_output("mid_rst_hs", h_sync, 1'b1);
      check_output("mid_rst_vs", v_sync, 1'b1);
      check_output("mid_rst_rgb", {r_out, g_out, b_out}, 12'h000);
      check_output("mid_rst_vis", video_on, 1'b0);
      check_output("mid_rst_xy", {x, y}, 20'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("hold_rst_fs", frame_start, 1'b0);
      rst   = 1'b1;
      n_cur = -1;
      step();
      check_output("rel_fs", frame_start, 1'b1);
      check_output("rel_rgb", {r_out, g_out, b_out}, 12'hFFF);
      check_pix("rel_5_3", 0, 5, 3, 12'hFFF, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
